sync_fifo_thr: RTL and testbench

SYNC_FIFO_THR -- requirements
Module: sync_fifo_thr

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo_thr.sv | 152 +++++++++++++++
 tb/tb_sync_fifo_thr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types: status flag bundle and the threshold-parameter range check.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic bit fifo_params_ok(input int depth, input int alfull, input int alempty);
    return (alfull >= 1) && (alfull <= depth) && (alempty >= 0) && (alempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int BW      = 32,
  parameter int BW_ADDR = 7
) (
  input  logic               clk,
  input  logic               we,
  input  logic [BW_ADDR-1:0] waddr,
  input  logic [BW-1:0]      wdata,
  input  logic [BW_ADDR-1:0] raddr,
  output logic [BW-1:0]      rdata
);

  logic [BW-1:0] mem_q [2**BW_ADDR];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, flush, and optional first-word-fall-through.
module sync_fifo_thr
  import fifo_pkg::*;
#(
  parameter int BW      = 32,
  parameter int BW_ADDR = 7,
  parameter int ALFULL  = 120,
  parameter int ALEMPTY = 8,
  parameter int FWFT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [BW-1:0]    din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [BW-1:0]    dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [BW_ADDR:0] data_count,
  output logic             overflow,
  output logic             underflow
);

  localparam int               DEPTH     = 2**BW_ADDR;
  localparam logic [BW_ADDR:0] DEPTH_C   = (BW_ADDR+1)'(DEPTH);
  localparam logic [BW_ADDR:0] ALFULL_C  = (BW_ADDR+1)'(ALFULL);
  localparam logic [BW_ADDR:0] ALEMPTY_C = (BW_ADDR+1)'(ALEMPTY);
  localparam logic [BW_ADDR:0] ONE_C     = (BW_ADDR+1)'(1);

  if (!fifo_params_ok(DEPTH, ALFULL, ALEMPTY)) begin : g_param_err
    $fatal(1, "sync_fifo_thr: ALFULL or ALEMPTY out of range");
  end

  logic [BW_ADDR:0] wr_ptr_q, wr_ptr_d;
  logic [BW_ADDR:0] rd_ptr_q, rd_ptr_d;
  logic [BW_ADDR:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [BW-1:0]    dout_q, dout_d;
  logic             active_q, active_d;
  logic             wr_acc_s, rd_acc_s;
  logic             full_s, empty_s;
  logic [BW-1:0]    rd_data_s;
  fifo_status_t     status_s;

  fifo_ram #(.BW(BW), .BW_ADDR(BW_ADDR)) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q[BW_ADDR-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[BW_ADDR-1:0]),
    .rdata (rd_data_s)
  );

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);

  // active_q stays low for the first edge after reset release so no access lands there
  always_comb begin
    active_d = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (!active_q) begin
      count_d = count_q;
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = ovf_q & ~clr_err;
      udf_d    = udf_q & ~clr_err;
    end else begin
      wr_acc_s = wr_en & ~full_s;
      rd_acc_s = rd_en & ~empty_s;
      ovf_d    = (ovf_q & ~clr_err) | (wr_en & full_s);
      udf_d    = (udf_q & ~clr_err) | (rd_en & empty_s);
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
        dout_d   = rd_data_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      active_q <= active_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // status bundle from the registered count and sticky flags
  always_comb begin
    status_s.full         = full_s;
    status_s.empty        = empty_s;
    status_s.almost_full  = (count_q >= ALFULL_C);
    status_s.almost_empty = (count_q <= ALEMPTY_C);
    status_s.overflow     = ovf_q;
    status_s.underflow    = udf_q;
  end

  assign full         = status_s.full;
  assign empty        = status_s.empty;
  assign almost_full  = status_s.almost_full;
  assign almost_empty = status_s.almost_empty;
  assign overflow     = status_s.overflow;
  assign underflow    = status_s.underflow;
  assign data_count   = count_q;

  if (FWFT != 0) begin : g_fwft
    assign dout = rd_data_s;
  end else begin : g_std
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Randomised + directed bench for sync_fifo_thr: a standard and a FWFT instance
// share stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_thr;

  localparam int BW = 8;
  localparam int BA = 3;
  localparam int DEPTH = 8;
  localparam int ALF = 6;
  localparam int ALE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [BW-1:0] din = '0;

  logic [BW-1:0] dout0, dout1;
  logic full0, empty0, afull0, aempty0, ovf0, udf0;
  logic full1, empty1, afull1, aempty1, ovf1, udf1;
  logic [BA:0] cnt0, cnt1;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  logic [BW-1:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0, m_act = 1'b0;
  logic [BW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_fifo_thr #(.BW(BW), .BW_ADDR(BA), .ALFULL(ALF), .ALEMPTY(ALE), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .dout(dout0), .full(full0), .empty(empty0),
    .almost_full(afull0), .almost_empty(aempty0), .data_count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  sync_fifo_thr #(.BW(BW), .BW_ADDR(BA), .ALFULL(ALF), .ALEMPTY(ALE), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .dout(dout1), .full(full1), .empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .data_count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_act = 1'b0;
  endtask

  // one clock edge of the FIFO's behaviour as seen from the ports
  task automatic model_step();
    int n;
    n = q.size();
    if (!rst_n) begin
      model_reset();
    end else if (!m_act) begin
      m_act = 1'b1;
    end else if (flush) begin
      q.delete();
      if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (wr_en && n == DEPTH) m_ovf = 1'b1;
      if (rd_en && n == 0) m_udf = 1'b1;
      if (rd_en && n > 0) m_dout = q.pop_front();
      if (wr_en && n < DEPTH) q.push_back(din);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"}, cnt0, 0);
    chk({tag, "_empty"}, empty0, 1);
    chk({tag, "_aempty"}, aempty0, 1);
    chk({tag, "_full"}, full0, 0);
    chk({tag, "_afull"}, afull0, 0);
    chk({tag, "_ovf"}, ovf0, 0);
    chk({tag, "_udf"}, udf0, 0);
    chk({tag, "_dout"}, dout0, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
    chk({tag, "_empty1"}, empty1, 1);
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("count", cnt0, n);
      chk("full", full0, n == DEPTH);
      chk("empty", empty0, n == 0);
      chk("almost_full", afull0, n >= ALF);
      chk("almost_empty", aempty0, n <= ALE);
      chk("overflow", ovf0, m_ovf);
      chk("underflow", udf0, m_udf);
      chk("dout_std", dout0, m_dout);
      chk("count_fwft", cnt1, n);
      chk("empty_fwft", empty1, n == 0);
      chk("full_fwft", full1, n == DEPTH);
      chk("afull_fwft", afull1, n >= ALF);
      chk("aempty_fwft", aempty1, n <= ALE);
      chk("ovf_fwft", ovf1, m_ovf);
      chk("udf_fwft", udf1, m_udf);
      if (n > 0) chk("dout_fwft", dout1, q[0]);
    end
  end

  initial begin
    int wp, rp;
    model_reset();
    #2;
    chk_reset_vals("reset");
    chk_en = 1'b1;
    cycle(); cycle();
    rst_n = 1'b1;
    // first edge after release: a write must be ignored
    wr_en = 1'b1; din = 8'hEE;
    cycle();
    chk("release_ignored", cnt0, 0);
    idle_in();
    cycle();

    // FWFT: single write shows up on dout without a read
    wr_en = 1'b1; din = 8'h5C;
    cycle();
    idle_in();
    chk("fwft_dout", dout1, 8'h5C);
    chk("fwft_empty", empty1, 0);
    rd_en = 1'b1;
    cycle();
    idle_in();
    chk("std_dout_5c", dout0, 8'h5C);

    // fill
    for (int k = 1; k <= DEPTH; k++) begin
      wr_en = 1'b1; din = 8'(8'h0F + k);
      cycle();
      chk("fill_afull", afull0, k >= ALF);
      chk("fill_full", full0, k == DEPTH);
    end
    din = 8'hAA;
    cycle();
    idle_in();
    chk("ovf_set", ovf0, 1);
    chk("ovf_cnt", cnt0, 8);
    clr_err = 1'b1;
    cycle();
    idle_in();
    chk("ovf_clr", ovf0, 0);

    // drain
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      cycle();
      chk("drain_dout", dout0, 8'(8'h10 + i));
    end
    chk("drain_empty", empty0, 1);
    cycle();
    idle_in();
    chk("udf_set", udf0, 1);
    chk("udf_dout", dout0, 8'h17);
    chk("udf_cnt", cnt0, 0);
    clr_err = 1'b1;
    rd_en = 1'b1;
    cycle();
    idle_in();
    chk("udf_priority", udf0, 1);
    clr_err = 1'b1;
    cycle();
    idle_in();
    chk("udf_clr", udf0, 0);

    // simultaneous access across pointer wrap
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; din = 8'(8'h20 + i);
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h30 + i);
      cycle();
      chk("wrap_cnt", cnt0, 4);
      chk("wrap_dout", dout0, (i < 4) ? 8'(8'h20 + i) : 8'(8'h30 + i - 4));
    end
    idle_in();

    // flush keeps sticky flags
    flush = 1'b1; cycle(); idle_in();
    rd_en = 1'b1; cycle(); idle_in();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 8'(8'h40 + i);
      cycle();
    end
    idle_in();
    chk("pre_flush_cnt", cnt0, 5);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    cycle();
    idle_in();
    chk("flush_cnt", cnt0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_udf_kept", udf0, 1);

    // reset mid-burst
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'(8'h60 + i);
      cycle();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midreset");
    cycle();
    rst_n = 1'b1;
    idle_in();
    cycle();

    // randomised traffic with varying fill pressure
    for (int blk = 0; blk < 10; blk++) begin
      wp = 20 + 8 * blk;
      rp = 90 - 8 * blk;
      for (int c = 0; c < 80; c++) begin
        wr_en   = ($urandom_range(99) < wp);
        rd_en   = ($urandom_range(99) < rp);
        din     = 8'($urandom);
        clr_err = ($urandom_range(99) < 5);
        flush   = ($urandom_range(99) < 2);
        if ($urandom_range(299) == 0) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          chk_reset_vals("rand_reset");
          cycle();
          rst_n = 1'b1;
        end
        cycle();
      end
    end
    idle_in();
    cycle();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
